// File: rtl/aes_pkg.sv
// Shared AES types: cipher operation encoding and key-schedule controller states.
package aes_pkg;

    typedef enum logic [1:0] {
        CIPH_ENC = 2'b01,
        CIPH_DEC = 2'b10
    } ciph_op_e;

    typedef enum logic [2:0] {
        KSC_IDLE,
        KSC_CLEAR,
        KSC_RUN,
        KSC_DONE,
        KSC_WIPE
    } ksc_state_e;

    localparam int AES128_NUM_ROUNDS = 10;

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Request/acknowledge link between the key-schedule sequencer (master)
// and the key-expansion stage (slave).
interface aes_key_sched_ctrl_if #(
    parameter int RoundW = 4
);
    logic              kx_clear_o;
    logic              kx_en_o;
    logic [1:0]        kx_op_o;
    logic [RoundW-1:0] kx_round_o;
    logic [255:0]      kx_key_o;
    logic              kx_req_i;
    logic [255:0]      kx_key_i;
    logic              kx_ack_o;

    modport master (
        output kx_clear_o, kx_en_o, kx_op_o, kx_round_o, kx_key_o, kx_ack_o,
        input  kx_req_i, kx_key_i
    );

    modport slave (
        input  kx_clear_o, kx_en_o, kx_op_o, kx_round_o, kx_key_o, kx_ack_o,
        output kx_req_i, kx_key_i
    );
endinterface

// File: rtl/aes_rkey_table.sv
// Round-key register file with one write port and a registered, range/valid-checked read port.
// AES_KSC_ZEROIZE_EN adds a sequential wipe counter zeroing one entry per cycle.
module aes_rkey_table
    import aes_pkg::*;
#(
    parameter int NumRounds = AES128_NUM_ROUNDS,
    parameter int KeyW      = 128,
    parameter int RoundW    = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [RoundW-1:0] waddr_i,
    input  logic [KeyW-1:0]   wdata_i,
`ifdef AES_KSC_ZEROIZE_EN
    input  logic              wipe_en_i,
    output logic              wipe_last_o,
`endif
    input  logic [RoundW-1:0] rd_idx_i,
    input  logic              tbl_valid_i,
    output logic [KeyW-1:0]   rd_data_o,
    output logic              rd_err_o
);
    localparam int Depth = NumRounds + 1;
    localparam logic [RoundW-1:0] LastIdx = RoundW'(NumRounds);

    logic [KeyW-1:0] mem_q [Depth];
    logic [KeyW-1:0] mem_d [Depth];
    logic [KeyW-1:0] rd_data_q, rd_data_d;
    logic            rd_err_q, rd_err_d;

`ifdef AES_KSC_ZEROIZE_EN
    logic [RoundW-1:0] wipe_cnt_q, wipe_cnt_d;
    assign wipe_last_o = (wipe_cnt_q == LastIdx);
`endif

    always_comb begin
        mem_d = mem_q;
        if (we_i && (waddr_i <= LastIdx)) begin
            mem_d[waddr_i] = wdata_i;
        end
`ifdef AES_KSC_ZEROIZE_EN
        // Counter parks at 0 outside a wipe so every wipe covers the full table.
        wipe_cnt_d = '0;
        if (wipe_en_i) begin
            mem_d[wipe_cnt_q] = '0;
            wipe_cnt_d = (wipe_cnt_q == LastIdx) ? '0 : wipe_cnt_q + RoundW'(1);
        end
`endif
    end

    always_comb begin
        rd_err_d  = (rd_idx_i > LastIdx) || !tbl_valid_i;
        rd_data_d = rd_err_d ? '0 : mem_q[rd_idx_i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
`ifdef AES_KSC_ZEROIZE_EN
            wipe_cnt_q <= '0;
`endif
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
`ifdef AES_KSC_ZEROIZE_EN
            wipe_cnt_q <= wipe_cnt_d;
`endif
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_err_o  = rd_err_q;
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Key-schedule sequencer: steps the expansion stage through all rounds and stores the round keys.
// AES_KSC_ZEROIZE_EN adds a WIPE state that zeroes the table on every abort and start.
//
// state     | meaning
// IDLE      | waiting for start; table readable when tbl_valid_o
// CLEAR     | one-cycle clear pulse, seed expansion stage with cipher key
// RUN       | request rounds 0..NumRounds, capture each key on kx_req_i
// DONE      | one-cycle done pulse, mark table valid
// WIPE      | zero table one entry per cycle (zeroize build only)
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NumRounds = AES128_NUM_ROUNDS,
    parameter int KeyW      = 128,
    parameter int RoundW    = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  ciph_op_e                    op_i,
    input  logic [KeyW-1:0]             key_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        tbl_valid_o,
    aes_key_sched_ctrl_if.master        kx,
    input  logic [RoundW-1:0]           rd_idx_i,
    output logic [KeyW-1:0]             rd_data_o,
    output logic                        rd_err_o
);
    localparam logic [RoundW-1:0] LastIdx = RoundW'(NumRounds);

    ksc_state_e        state_q, state_d;
    logic [RoundW-1:0] round_q, round_d;
    logic [KeyW-1:0]   key_q, key_d;
    logic [1:0]        op_q, op_d;
    logic [255:0]      kx_key_q, kx_key_d;
    logic              tbl_valid_q, tbl_valid_d;
    logic              tbl_we;
    logic [RoundW-1:0] tbl_waddr;

`ifdef AES_KSC_ZEROIZE_EN
    logic wipe_to_clear_q, wipe_to_clear_d;
    logic wipe_en, wipe_last;
`endif

    // Decrypt schedules land reversed so the consumer always starts at index 0.
    assign tbl_waddr = (op_q == CIPH_DEC) ? (LastIdx - round_q) : round_q;

    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        key_d         = key_q;
        op_d          = op_q;
        kx_key_d      = kx_key_q;
        tbl_valid_d   = tbl_valid_q;
        done_o        = 1'b0;
        kx.kx_clear_o = 1'b0;
        kx.kx_en_o    = 1'b0;
        kx.kx_ack_o   = 1'b0;
        tbl_we        = 1'b0;
`ifdef AES_KSC_ZEROIZE_EN
        wipe_to_clear_d = wipe_to_clear_q;
        wipe_en         = 1'b0;
`endif
        case (state_q)
            KSC_IDLE: begin
                if (start_i) begin
                    key_d       = key_i;
                    op_d        = op_i;
                    tbl_valid_d = 1'b0;
`ifdef AES_KSC_ZEROIZE_EN
                    state_d         = KSC_WIPE;
                    wipe_to_clear_d = 1'b1;
`else
                    state_d = KSC_CLEAR;
`endif
                end
            end
            KSC_CLEAR: begin
                kx.kx_clear_o = 1'b1;
                round_d       = '0;
                kx_key_d      = 256'(key_q);
                state_d       = KSC_RUN;
            end
            KSC_RUN: begin
                kx.kx_en_o  = 1'b1;
                kx.kx_ack_o = kx.kx_req_i;
                if (kx.kx_req_i) begin
                    tbl_we   = 1'b1;
                    kx_key_d = kx.kx_key_i;
                    if (round_q == LastIdx) state_d = KSC_DONE;
                    else                    round_d = round_q + RoundW'(1);
                end
            end
            KSC_DONE: begin
                done_o      = 1'b1;
                tbl_valid_d = 1'b1;
                state_d     = KSC_IDLE;
            end
`ifdef AES_KSC_ZEROIZE_EN
            KSC_WIPE: begin
                wipe_en = 1'b1;
                if (wipe_last) state_d = wipe_to_clear_q ? KSC_CLEAR : KSC_IDLE;
            end
`endif
            default: state_d = KSC_IDLE;
        endcase

        if (abort_i) begin
            round_d       = round_q;
            key_d         = key_q;
            op_d          = op_q;
            kx_key_d      = kx_key_q;
            tbl_valid_d   = 1'b0;
            done_o        = 1'b0;
            kx.kx_clear_o = 1'b1;
            kx.kx_en_o    = 1'b0;
            kx.kx_ack_o   = 1'b0;
            tbl_we        = 1'b0;
`ifdef AES_KSC_ZEROIZE_EN
            state_d         = KSC_WIPE;
            wipe_to_clear_d = 1'b0;
`else
            state_d = KSC_IDLE;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= KSC_IDLE;
            round_q     <= '0;
            key_q       <= '0;
            op_q        <= '0;
            kx_key_q    <= '0;
            tbl_valid_q <= 1'b0;
`ifdef AES_KSC_ZEROIZE_EN
            wipe_to_clear_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            key_q       <= key_d;
            op_q        <= op_d;
            kx_key_q    <= kx_key_d;
            tbl_valid_q <= tbl_valid_d;
`ifdef AES_KSC_ZEROIZE_EN
            wipe_to_clear_q <= wipe_to_clear_d;
`endif
        end
    end

    assign busy_o        = (state_q != KSC_IDLE);
    assign tbl_valid_o   = tbl_valid_q;
    assign kx.kx_op_o    = op_q;
    assign kx.kx_round_o = round_q;
    assign kx.kx_key_o   = kx_key_q;

    aes_rkey_table #(
        .NumRounds (NumRounds),
        .KeyW      (KeyW),
        .RoundW    (RoundW)
    ) u_table (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .we_i        (tbl_we),
        .waddr_i     (tbl_waddr),
        .wdata_i     (kx.kx_key_i[KeyW-1:0]),
`ifdef AES_KSC_ZEROIZE_EN
        .wipe_en_i   (wipe_en),
        .wipe_last_o (wipe_last),
`endif
        .rd_idx_i    (rd_idx_i),
        .tbl_valid_i (tbl_valid_q),
        .rd_data_o   (rd_data_o),
        .rd_err_o    (rd_err_o)
    );
endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Upstream sequencer for the AES key-expansion stage.
- Latches a 128-bit cipher key and clears the expansion stage, then steps it through rounds 0..NumRounds with its req/ack handshake.
- Captures every round key into an on-chip table, which the cipher datapath reads back by round index.
- Decrypt runs store keys reversed, so the consumer always reads index 0 first.

Parameters:
- NumRounds, 10, last round index; table depth is NumRounds+1.
- KeyW, 128, cipher/round key width.
- RoundW, 4, round index width; must satisfy 2^RoundW > NumRounds.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start schedule; accepted only in IDLE
- abort_i  in  1  abort/clear; wins over everything
- op_i  in  2  ciph_op_e (ENC / DEC), latched at start
- key_i  in  KeyW  cipher key, latched at start
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse when the table is complete
- tbl_valid_o  out  1  table holds a complete schedule
- kx_clear_o  out  1  clear pulse to expansion stage
- kx_en_o  out  1  enable/request to expansion stage
- kx_op_o  out  2  latched op
- kx_round_o  out  RoundW  current round index
- kx_key_o  out  256  key to expansion stage; upper 128 bits zero
- kx_req_i  in  1  expansion stage output valid
- kx_key_i  in  256  expanded key; bits [127:0] used
- kx_ack_o  out  1  acknowledge of kx_req_i
- rd_idx_i  in  RoundW  table read index
- rd_data_o  out  KeyW  round key, registered
- rd_err_o  out  1  registered; index > NumRounds or table invalid

Behaviour:
- Reset (async, rst_ni low):
  - State IDLE; round counter 0.
  - All outputs 0, including rd_data_o, tbl_valid_o and every kx_* output.
  - Table contents 0.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - start_i=1 and abort_i=0: latch key_i and op_i, tbl_valid_o<=0, go to CLEAR.
  - Otherwise stay.
- CLEAR:
  - kx_clear_o=1 for exactly this one cycle.
  - Round counter <= 0, kx_key_o <= {128'b0, latched key}.
  - Next state RUN.
- RUN:
  - kx_en_o=1, kx_round_o = round counter.
  - kx_ack_o = kx_req_i, combinational, same cycle.
  - On kx_req_i=1:
    - Write kx_key_i[127:0] to entry `round` (ENC) or `NumRounds-round` (DEC).
    - kx_key_o <= kx_key_i, fed back as the next-round seed.
    - If round==NumRounds, go to DONE; else round++.
  - No timeout; RUN waits indefinitely for kx_req_i.
- DONE:
  - done_o=1 and tbl_valid_o<=1.
  - Next state IDLE.
  - Latency from start_i accept to done_o is 2 + (NumRounds+1) cycles when kx_req_i is held high.
- start_i while busy_o=1: ignored, not queued.
- abort_i=1, any state:
  - Next state IDLE; tbl_valid_o<=0.
  - kx_clear_o=1 that cycle; kx_en_o=0, kx_ack_o=0.
  - No table write occurs that cycle, even if kx_req_i=1.
  - abort_i with start_i in IDLE: abort wins, start dropped.
- Read port:
  - 1-cycle latency: rd_data_o <= table[rd_idx_i].
  - rd_err_o <= (rd_idx_i > NumRounds) | ~tbl_valid_o; in that case rd_data_o <= 0.
  - A read in the cycle of a write to the same entry returns the old value.
  - Reads during RUN always flag rd_err_o, because tbl_valid_o=0.
- Latched key and op are frozen from start until the return to IDLE.

Optional Feature:
- Macro: AES_KSC_ZEROIZE_EN.
- Defined:
  - abort_i and every new start_i wipe the table before use, adding state WIPE.
  - WIPE writes 0 to one entry per cycle, indices 0..NumRounds, then goes to IDLE (abort) or CLEAR (start).
  - busy_o stays high during WIPE.
- Not defined:
  - No WIPE state; abort/start only drop tbl_valid_o.
  - Stale entries remain but are unreadable because rd_err_o masks them.

Decomposition:
- Shared package aes_pkg gains:
  - ksc_state_e (IDLE, CLEAR, RUN, DONE, WIPE).
  - Constant AES128_NUM_ROUNDS=10.
  - Reuse of existing ciph_op_e.
- Natural sub-module: aes_rkey_table.
  - NumRounds+1 x KeyW register file.
  - Single write port, single registered read port, optional sequential wipe counter.

Test Plan:
- Use key 000102030405060708090a0b0c0d0e0f, ENC, kx_req_i always 1:
  - done_o 13 cycles after start.
  - Read idx 0 -> 000102030405060708090a0b0c0d0e0f.
  - Read idx 10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- Same key, DEC:
  - Read idx 0 -> 13111d7fe3944a17f307a78b4d2b30c5.
  - Read idx 10 -> 000102030405060708090a0b0c0d0e0f.
- Throttle kx_req_i to 1 cycle in 3:
  - Table contents identical to the first case.
  - kx_ack_o exactly mirrors kx_req_i; kx_round_o holds while req is low.
- abort_i in RUN at round 4:
  - IDLE next cycle; kx_clear_o=1 that cycle; tbl_valid_o=0.
  - Any read -> rd_err_o=1, rd_data_o=0.
  - With the macro: 11 WIPE cycles; all entries 0.
- Second start_i pulse asserted while busy: ignored; exactly one done_o.
- Read idx 11 after a completed run: rd_err_o=1, rd_data_o=0.
- Reset asserted mid-RUN: all outputs 0 immediately (async); state IDLE after release.
